// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port and the shared memory port.
// Requests are level-held until their one-cycle ACK; a memory access ends on the edge with M_RDY=1.
interface mem_port_arbiter_if;
    logic        I_REQ;
    logic [31:0] I_ADDR;
    logic [31:0] I_RDATA;
    logic        I_ACK;
    logic        D_RD;
    logic        D_WR;
    logic [31:0] D_ADDR;
    logic [31:0] D_WDATA;
    logic [2:0]  D_LEN;
    logic [31:0] D_RDATA;
    logic        D_ACK;
    logic [31:0] M_ADDR;
    logic [31:0] M_WDATA;
    logic [3:0]  M_BE;
    logic        M_CS;
    logic        M_WE;
    logic [31:0] M_RDATA;
    logic        M_RDY;
    logic        HLT;
    logic        BERR;

    modport slave (
        input  I_REQ, I_ADDR, D_RD, D_WR, D_ADDR, D_WDATA, D_LEN, M_RDATA, M_RDY,
        output I_RDATA, I_ACK, D_RDATA, D_ACK, M_ADDR, M_WDATA, M_BE, M_CS, M_WE, HLT, BERR
    );

    modport master (
        output I_REQ, I_ADDR, D_RD, D_WR, D_ADDR, D_WDATA, D_LEN, M_RDATA, M_RDY,
        input  I_RDATA, I_ACK, D_RDATA, D_ACK, M_ADDR, M_WDATA, M_BE, M_CS, M_WE, HLT, BERR
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access,
// with byte-lane steering, access timeout and bus-error reporting.
module mem_port_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RES,
    mem_port_arbiter_if.slave bus,
    output logic [1:0]        o_dbg_state
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]    r_state;
    logic          r_gnt_d;
    logic          r_last_d;
    logic          r_we;
    logic          r_berr;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_cap;
    logic [2:0]    r_len;
    logic [CW-1:0] r_cnt;

    logic w_i_req;
    logic w_d_req;
    logic w_pick_d;
    logic w_d_err;
    logic w_access;
    logic w_resp;
    logic w_i_ack;
    logic w_d_ack;

    assign w_i_req  = bus.I_REQ;
    assign w_d_req  = bus.D_RD | bus.D_WR;
    // On a tie the side that was not granted last wins; a lone requester always wins.
    assign w_pick_d = w_d_req & (~w_i_req | ~r_last_d);

    always_comb begin
        w_d_err = bus.D_RD & bus.D_WR;
        case (bus.D_LEN)
            3'd1:    ;
            3'd2:    if (bus.D_ADDR[0]) w_d_err = 1'b1;
            3'd4:    if (bus.D_ADDR[1:0] != 2'b00) w_d_err = 1'b1;
            default: w_d_err = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            r_state  <= S_IDLE;
            r_gnt_d  <= 1'b0;
            r_last_d <= 1'b0;
            r_we     <= 1'b0;
            r_berr   <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cap    <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_i_req | w_d_req) begin
                        r_gnt_d  <= w_pick_d;
                        r_last_d <= w_pick_d;
                        r_cnt    <= '0;
                        if (w_pick_d) begin
                            r_addr  <= bus.D_ADDR;
                            r_wdata <= bus.D_WDATA;
                            r_len   <= bus.D_LEN;
                            r_we    <= bus.D_WR & ~bus.D_RD;
                            // Malformed data requests never touch memory.
                            if (w_d_err) begin
                                r_state <= S_RESP;
                                r_berr  <= 1'b1;
                                r_cap   <= '0;
                            end else begin
                                r_state <= S_ACCESS;
                            end
                        end else begin
                            r_addr  <= bus.I_ADDR;
                            r_len   <= 3'd4;
                            r_we    <= 1'b0;
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (bus.M_RDY) begin
                        r_cap   <= bus.M_RDATA;
                        r_state <= S_RESP;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_cap   <= '0;
                        r_berr  <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_berr  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_access = (r_state == S_ACCESS);
    assign w_resp   = (r_state == S_RESP);
    assign w_i_ack  = w_resp & ~r_gnt_d;
    assign w_d_ack  = w_resp & r_gnt_d;

    always_comb begin
        bus.M_BE    = 4'b0000;
        bus.M_WDATA = '0;
        if (w_access) begin
            case (r_len)
                3'd1:    bus.M_WDATA = {4{r_wdata[7:0]}};
                3'd2:    bus.M_WDATA = {2{r_wdata[15:0]}};
                default: bus.M_WDATA = r_wdata;
            endcase
            if (!r_we) begin
                bus.M_BE = 4'b1111;
            end else begin
                case (r_len)
                    3'd1:    bus.M_BE = 4'b0001 << r_addr[1:0];
                    3'd2:    bus.M_BE = 4'b0011 << {r_addr[1], 1'b0};
                    default: bus.M_BE = 4'b1111;
                endcase
            end
        end
    end

    assign bus.M_CS    = w_access;
    assign bus.M_WE    = w_access & r_we;
    assign bus.M_ADDR  = w_access ? {r_addr[31:2], 2'b00} : 32'h0;
    assign bus.I_ACK   = w_i_ack;
    assign bus.D_ACK   = w_d_ack;
    assign bus.BERR    = w_resp & r_berr;
    assign bus.I_RDATA = r_cap;
    assign bus.D_RDATA = r_cap >> {r_addr[1:0], 3'b000};
    assign bus.HLT     = (w_i_req & ~w_i_ack) | (w_d_req & ~w_d_ack);
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random and directed traffic against a lane-level
// reference model, with a memory responder and an independent monitor.
module tb_mem_port_arbiter;
    localparam int W_MOP = 69;  // {we, be[3:0], addr[31:0], wdata[31:0]}
    localparam int W_RSP = 35;  // {is_d, berr, chk_data, rdata[31:0]}

    logic       clk = 1'b0;
    logic       RES = 1'b0;
    logic [1:0] dbg_state;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT(15)) dut (
        .CLK        (clk),
        .RES        (RES),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    logic [W_MOP-1:0] mop_q[$];
    logic [W_RSP-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cs_rises = 0;
    int rdy_mode = 0;          // 0 random, 1 always ready, 2 never ready
    logic        override_en = 1'b0;
    logic [31:0] override_val = 32'h0;
    logic        last_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (override_en) return override_val;
        return ({a[31:2], 2'b00} * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Memory responder
    initial begin
        bus.M_RDY = 1'b0;
        bus.M_RDATA = 32'h0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       bus.M_RDY = ($urandom_range(0, 3) != 0);
                1:       bus.M_RDY = 1'b1;
                default: bus.M_RDY = 1'b0;
            endcase
            bus.M_RDATA = mem_word(bus.M_ADDR);
        end
    end

    // Reference model
    task automatic push_fetch(input logic [31:0] a);
        mop_q.push_back({1'b0, 4'hF, a[31:2], 2'b00, 32'h0});
        exp_q.push_back({1'b0, 1'b0, 1'b1, mem_word(a)});
    endtask

    task automatic push_data(input logic rd, input logic wr, input logic [31:0] a,
                             input int len, input logic [31:0] wd);
        logic [3:0]  be;
        logic [31:0] wexp;
        int base;
        if ((rd && wr) || !(len == 1 || len == 2 || len == 4) ||
            (len == 2 && a[0]) || (len == 4 && a[1:0] != 2'b00)) begin
            exp_q.push_back({1'b1, 1'b1, 1'b0, 32'h0});
            return;
        end
        if (wr) begin
            base = (len == 4) ? 0 : (len == 2) ? 2 * int'(a[1]) : int'(a[1:0]);
            for (int k = 0; k < 4; k++) begin
                be[k] = (k >= base) && (k < base + len);
                wexp[8*k +: 8] = wd[8*(k % len) +: 8];
            end
            mop_q.push_back({1'b1, be, a[31:2], 2'b00, wexp});
            exp_q.push_back({1'b1, 1'b0, 1'b0, 32'h0});
        end else begin
            mop_q.push_back({1'b0, 4'hF, a[31:2], 2'b00, 32'h0});
            exp_q.push_back({1'b1, 1'b0, 1'b1, mem_word(a) >> (8 * int'(a[1:0]))});
        end
    endtask

    task automatic predict(input logic use_i, input logic use_d, input logic [31:0] ia,
                           input logic rd, input logic wr, input logic [31:0] da,
                           input int len, input logic [31:0] wd);
        if (use_i && use_d) begin
            if (!last_d) begin
                push_data(rd, wr, da, len, wd);
                push_fetch(ia);
            end else begin
                push_fetch(ia);
                push_data(rd, wr, da, len, wd);
            end
        end else if (use_d) begin
            push_data(rd, wr, da, len, wd);
            last_d = 1'b1;
        end else if (use_i) begin
            push_fetch(ia);
            last_d = 1'b0;
        end
    endtask

    // Monitor
    initial begin
        logic prev_cs;
        logic [W_MOP-1:0] m;
        logic [W_RSP-1:0] r;
        logic hlt_exp;
        prev_cs = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!RES) begin
                prev_cs = 1'b0;
                continue;
            end
            hlt_exp = (bus.I_REQ & ~bus.I_ACK) | ((bus.D_RD | bus.D_WR) & ~bus.D_ACK);
            chk("hlt", 32'(bus.HLT), 32'(hlt_exp));
            if (bus.M_CS && !prev_cs) begin
                cs_rises++;
                if (mop_q.size() == 0) begin
                    chk("unexpected_access", 32'(bus.M_CS), 32'h0);
                end else begin
                    m = mop_q.pop_front();
                    chk("m_addr", bus.M_ADDR, m[63:32]);
                    chk("m_be", 32'(bus.M_BE), 32'(m[67:64]));
                    chk("m_we", 32'(bus.M_WE), 32'(m[68]));
                    if (m[68]) chk("m_wdata", bus.M_WDATA, m[31:0]);
                end
            end
            prev_cs = bus.M_CS;
            if (bus.I_ACK || bus.D_ACK) begin
                if (bus.I_ACK && bus.D_ACK) begin
                    chk("double_ack", 32'(bus.I_ACK), 32'(~bus.D_ACK));
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'(bus.I_ACK | bus.D_ACK), 32'h0);
                end else begin
                    r = exp_q.pop_front();
                    chk("ack_is_d", 32'(bus.D_ACK), 32'(r[34]));
                    chk("berr", 32'(bus.BERR), 32'(r[33]));
                    if (r[32]) chk("rdata", bus.D_ACK ? bus.D_RDATA : bus.I_RDATA, r[31:0]);
                end
            end else if (bus.BERR) begin
                chk("berr_without_ack", 32'(bus.BERR), 32'h0);
            end
        end
    end

    task automatic clear_inputs();
        bus.I_REQ = 1'b0;
        bus.I_ADDR = 32'h0;
        bus.D_RD = 1'b0;
        bus.D_WR = 1'b0;
        bus.D_ADDR = 32'h0;
        bus.D_WDATA = 32'h0;
        bus.D_LEN = 3'd0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_m_cs"}, 32'(bus.M_CS), 32'h0);
        chk({tag, "_m_we"}, 32'(bus.M_WE), 32'h0);
        chk({tag, "_m_be"}, 32'(bus.M_BE), 32'h0);
        chk({tag, "_m_addr"}, bus.M_ADDR, 32'h0);
        chk({tag, "_m_wdata"}, bus.M_WDATA, 32'h0);
        chk({tag, "_acks"}, 32'({bus.I_ACK, bus.D_ACK, bus.BERR}), 32'h0);
        chk({tag, "_i_rdata"}, bus.I_RDATA, 32'h0);
        chk({tag, "_d_rdata"}, bus.D_RDATA, 32'h0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        RES = 1'b0;
        clear_inputs();
        #1;
        check_zero("reset");
        exp_q.delete();
        mop_q.delete();
        last_d = 1'b0;
        repeat (2) @(negedge clk);
        RES = 1'b1;
    endtask

    task automatic do_txn(input logic use_i, input logic use_d, input logic [31:0] ia,
                          input logic rd, input logic wr, input logic [31:0] da,
                          input int len, input logic [31:0] wd);
        logic i_pend, d_pend;
        int n;
        @(negedge clk);
        bus.I_REQ = use_i;
        bus.I_ADDR = ia;
        bus.D_RD = use_d & rd;
        bus.D_WR = use_d & wr;
        bus.D_ADDR = da;
        bus.D_LEN = 3'(len);
        bus.D_WDATA = wd;
        predict(use_i, use_d, ia, rd, wr, da, len, wd);
        i_pend = use_i;
        d_pend = use_d;
        n = 0;
        while ((i_pend || d_pend) && n < 200) begin
            @(negedge clk);
            n++;
            if (i_pend && bus.I_ACK) begin
                bus.I_REQ = 1'b0;
                i_pend = 1'b0;
            end
            if (d_pend && bus.D_ACK) begin
                bus.D_RD = 1'b0;
                bus.D_WR = 1'b0;
                d_pend = 1'b0;
            end
        end
        if (i_pend || d_pend) begin
            chk("ack_wait_expired", 32'({i_pend, d_pend}), 32'h0);
            apply_reset();
        end
    endtask

    initial begin
        int cs_before, cs_cycles, n;
        logic got_ack;
        int kind, len, sel;
        logic [31:0] da;
        clear_inputs();
        apply_reset();
        chk("reset_state", 32'(dbg_state), 32'h0);

        // Minimum-latency fetch
        rdy_mode = 1;
        override_en = 1'b1;
        override_val = 32'h12345678;
        @(negedge clk);
        bus.I_REQ = 1'b1;
        bus.I_ADDR = 32'h100;
        predict(1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 0, 32'h0);
        @(posedge clk); #1;
        chk("lat_cs_cycle1", 32'(bus.M_CS), 32'h1);
        @(posedge clk); #1;
        chk("lat_ack_cycle2", 32'(bus.I_ACK), 32'h1);
        chk("lat_i_rdata", bus.I_RDATA, 32'h12345678);
        @(negedge clk);
        bus.I_REQ = 1'b0;
        @(posedge clk); #1;
        chk("lat_idle_cycle3", 32'(bus.M_CS), 32'h0);

        // Half-word read lane extraction and misaligned word error
        override_val = 32'hBEEF1234;
        do_txn(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h402, 2, 32'h0);
        chk("d_rdata_half", bus.D_RDATA, 32'h0000BEEF);
        cs_before = cs_rises;
        do_txn(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h402, 4, 32'h0);
        chk("err_no_cs", 32'(cs_rises - cs_before), 32'h0);
        override_en = 1'b0;

        // Byte write lane steering
        do_txn(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h203, 1, 32'h000000AB);

        // Ties after reset alternate D,I,D,I
        apply_reset();
        rdy_mode = 0;
        do_txn(1'b1, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h2000, 4, 32'h0);
        do_txn(1'b1, 1'b1, 32'h1004, 1'b1, 1'b0, 32'h2004, 4, 32'h0);

        // Timeout with M_RDY held low
        rdy_mode = 2;
        @(negedge clk);
        bus.I_REQ = 1'b1;
        bus.I_ADDR = 32'h800;
        mop_q.push_back({1'b0, 4'hF, 32'h800, 32'h0});
        exp_q.push_back({1'b0, 1'b1, 1'b1, 32'h0});
        last_d = 1'b0;
        cs_cycles = 0;
        got_ack = 1'b0;
        for (n = 0; n < 60 && !got_ack; n++) begin
            @(negedge clk);
            if (bus.I_ACK) got_ack = 1'b1;
            else if (bus.M_CS) cs_cycles++;
        end
        bus.I_REQ = 1'b0;
        chk("timeout_ack", 32'(got_ack), 32'h1);
        chk("timeout_cycles", 32'(cs_cycles), 32'd15);

        // Inputs changed and request dropped during ACCESS
        @(negedge clk);
        bus.D_WR = 1'b1;
        bus.D_ADDR = 32'h300;
        bus.D_LEN = 3'd4;
        bus.D_WDATA = 32'hCAFEF00D;
        predict(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h300, 4, 32'hCAFEF00D);
        @(negedge clk);
        bus.D_WR = 1'b0;
        bus.D_ADDR = 32'h777;
        bus.D_LEN = 3'd1;
        bus.D_WDATA = 32'h0;
        @(negedge clk); #1;
        chk("latched_addr", bus.M_ADDR, 32'h300);
        chk("latched_wdata", bus.M_WDATA, 32'hCAFEF00D);
        rdy_mode = 1;
        got_ack = 1'b0;
        for (n = 0; n < 20 && !got_ack; n++) begin
            @(negedge clk);
            if (bus.D_ACK) got_ack = 1'b1;
        end
        chk("dropped_req_ack", 32'(got_ack), 32'h1);

        // Reset in the middle of an access
        rdy_mode = 2;
        @(negedge clk);
        bus.D_RD = 1'b1;
        bus.D_ADDR = 32'h500;
        bus.D_LEN = 3'd4;
        predict(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h500, 4, 32'h0);
        repeat (3) @(negedge clk);
        chk("mid_access_cs", 32'(bus.M_CS), 32'h1);
        #2;
        RES = 1'b0;
        #1;
        check_zero("mid_reset");
        clear_inputs();
        exp_q.delete();
        mop_q.delete();
        last_d = 1'b0;
        repeat (2) @(negedge clk);
        RES = 1'b1;
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        do_txn(1'b1, 1'b1, 32'h600, 1'b0, 1'b1, 32'h702, 2, 32'h00005A3C);

        // Random traffic
        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 2);
            da = $urandom;
            sel = $urandom_range(0, 9);
            len = (sel < 3) ? 1 : (sel < 6) ? 2 : (sel < 9) ? 4 : $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                if (len == 4) da[1:0] = 2'b00;
                if (len == 2) da[0] = 1'b0;
            end
            sel = $urandom_range(0, 9);
            do_txn(kind != 1, kind != 0, $urandom, (sel == 0) || (sel < 5), (sel == 0) || (sel >= 5),
                   da, len, $urandom);
        end

        repeat (5) @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
        chk("mop_q_empty", 32'(mop_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: ACCESS cycles without M_RDY before bus error.
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port RES  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port I_REQ  input  1  instruction fetch request, held until I_ACK.
REQ-005 SHALL have port I_ADDR  input  32  fetch address; word access, [1:0] ignored.
REQ-006 SHALL have ports I_RDATA  output  32  and I_ACK  output  1  fetch data and one-cycle completion pulse.
REQ-007 SHALL have ports D_RD  input  1  and D_WR  input  1  data read/write request, held until D_ACK.
REQ-008 SHALL have ports D_ADDR  input  32,  D_WDATA  input  32,  D_LEN  input  3  (1/2/4 bytes).
REQ-009 SHALL have ports D_RDATA  output  32  and D_ACK  output  1.
REQ-010 SHALL have ports M_ADDR  output  32,  M_WDATA  output  32,  M_BE  output  4,  M_CS  output  1,  M_WE  output  1.
REQ-011 SHALL have ports M_RDATA  input  32  and M_RDY  input  1  memory response.
REQ-012 SHALL have ports HLT  output  1  pipeline stall and BERR  output  1  one-cycle bus-error pulse.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, RESP; one shared memory port, one access in flight.
REQ-014 In IDLE, with one valid request pending, SHALL grant it at the next edge and enter ACCESS.
REQ-015 On simultaneous I and D requests SHALL grant the requester not granted last (round-robin); last-grant flag updates on every grant.
REQ-016 In ACCESS SHALL drive M_CS=1, M_ADDR={addr[31:2],2'b00}, M_WE=1 only for D_WR grants; M_CS=0, M_WE=0 in all other states.
REQ-017 M_BE SHALL be 4'b1111 for reads and fetches; for writes LEN=1 -> 4'b0001<<addr[1:0], LEN=2 -> 4'b0011<<{addr[1],0}, LEN=4 -> 4'b1111.
REQ-018 M_WDATA SHALL replicate the low byte into all lanes for LEN=1, the low half into both halves for LEN=2, pass through for LEN=4.
REQ-019 ACCESS SHALL complete on the edge where M_RDY=1; read data captured into a register at that edge; FSM enters RESP.
REQ-020 In RESP SHALL pulse the granted requester's ACK for exactly one cycle, then return to IDLE.
REQ-021 D_RDATA SHALL equal captured word shifted right by 8*addr[1:0], upper bits zero; I_RDATA SHALL equal captured word unchanged.
REQ-022 Minimum latency with M_RDY tied 1: request at cycle 0, M_CS at cycle 1, ACK at cycle 2; next grant no earlier than cycle 3.
REQ-023 A timeout counter SHALL clear on grant and increment each ACCESS cycle with M_RDY=0; on reaching TIMEOUT, FSM enters RESP with read data 0 and BERR pulses with the ACK.
REQ-024 D_RD and D_WR both high, LEN not in {1,2,4}, LEN=2 with addr[0]=1, or LEN=4 with addr[1:0]!=0 SHALL be an error: no M_CS, go directly to RESP, D_ACK and BERR pulse.
REQ-025 Grant fields (requester, address, LEN, write data, direction) SHALL be latched at grant; input changes during ACCESS SHALL be ignored.
REQ-026 A request dropped before ACK SHALL still complete its access and pulse ACK.
REQ-027 HLT SHALL be combinational: (I_REQ & ~I_ACK) | ((D_RD|D_WR) & ~D_ACK).

Reset
REQ-028 RES low SHALL asynchronously force IDLE, timeout counter 0, last-grant=instruction, captured data 0, and ACK, BERR, M_CS, M_WE, M_BE, M_ADDR, M_WDATA, I_RDATA, D_RDATA all 0.
REQ-029 Reset asserted during ACCESS SHALL abandon the access with no ACK; first grant after release follows REQ-015.

Verification
REQ-030 I_REQ, I_ADDR=0x100, M_RDY=1, M_RDATA=0x12345678 -> M_CS at cycle 1, I_ACK at cycle 2, I_RDATA=0x12345678.
REQ-031 I_REQ and D_RD together after reset -> D granted first, then I; repeated ties alternate D,I,D,I.
REQ-032 D_WR, D_ADDR=0x203, D_LEN=1, D_WDATA=0xAB -> M_BE=4'b1000, M_WDATA=0xABABABAB, M_ADDR=0x200, M_WE=1.
REQ-033 D_RD, D_ADDR=0x402, D_LEN=2, M_RDATA=0xBEEF1234 -> D_RDATA=0x0000BEEF; D_LEN=4 at 0x402 -> BERR and D_ACK, M_CS never high.
REQ-034 M_RDY held 0, TIMEOUT=15 -> 15 ACCESS cycles, then ACK+BERR, RDATA=0, HLT high throughout until ACK.
REQ-035 RES pulsed low mid-ACCESS -> all outputs 0 immediately, no ACK, clean re-grant after release.
